// File: rtl/ex_mem_latch_if.sv
// rtl/ex_mem_latch_if.sv - EX/MEM pipeline register bus
// Groups EX-side inputs, pipeline control and registered MEM-side outputs.
interface ex_mem_latch_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              valid_ex;
  logic [REG_W-1:0]  rd_ex;
  logic              regWrite_ex;
  logic              load_ex;
  logic              store_ex;
  logic [REG_W-1:0]  rs1_ex;
  logic [REG_W-1:0]  rs2_ex;
  logic              usesRs1_ex;
  logic              usesRs2_ex;
  logic [DATA_W-1:0] aluResult_ex;
  logic [DATA_W-1:0] storeData_ex;
  logic              valid_mem;
  logic              regWrite_mem;
  logic              load_mem;
  logic              store_mem;
  logic [REG_W-1:0]  rd_mem;
  logic [DATA_W-1:0] aluResult_mem;
  logic [DATA_W-1:0] storeData_mem;
  logic              loadUse_stall;
  logic [CNT_W-1:0]  loadUseCount;

  modport master (
    output stall, flush, valid_ex, rd_ex, regWrite_ex, load_ex, store_ex,
           rs1_ex, rs2_ex, usesRs1_ex, usesRs2_ex, aluResult_ex, storeData_ex,
    input  valid_mem, regWrite_mem, load_mem, store_mem, rd_mem,
           aluResult_mem, storeData_mem, loadUse_stall, loadUseCount
  );

  modport slave (
    input  stall, flush, valid_ex, rd_ex, regWrite_ex, load_ex, store_ex,
           rs1_ex, rs2_ex, usesRs1_ex, usesRs2_ex, aluResult_ex, storeData_ex,
    output valid_mem, regWrite_mem, load_mem, store_mem, rd_mem,
           aluResult_mem, storeData_mem, loadUse_stall, loadUseCount
  );
endinterface

// File: rtl/ex_mem_latch.sv
// rtl/ex_mem_latch.sv - EX/MEM pipeline register with load-use interlock
// Flush beats stall beats interlock bubble beats normal capture.
module ex_mem_latch #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_mem_latch_if.slave   bus
);
  typedef enum logic {S_IDLE, S_BUBBLE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_valid;
  logic              r_rw;
  logic              r_load;
  logic              r_store;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_sd;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_hit;
  logic              w_lu_stall;

  // A load in MEM cannot forward its data, so any EX reader of its rd must wait.
  assign w_hit = r_valid & r_load & r_rw & bus.valid_ex &
                 ((bus.usesRs1_ex & (bus.rs1_ex == r_rd)) |
                  (bus.usesRs2_ex & (bus.rs2_ex == r_rd)));

  always_comb begin
    w_state_nxt = r_state;
    w_lu_stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_lu_stall = w_hit & ~bus.flush;
        if (w_hit & ~bus.stall & ~bus.flush) w_state_nxt = S_BUBBLE;
      end
      S_BUBBLE: begin
        if (bus.flush | ~bus.stall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_rd    <= '0;
      r_alu   <= '0;
      r_sd    <= '0;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_rd    <= '0;
      r_alu   <= '0;
      r_sd    <= '0;
    end else if (!bus.stall) begin
      if (w_lu_stall) begin
        r_valid <= 1'b0;
        r_rw    <= 1'b0;
        r_load  <= 1'b0;
        r_store <= 1'b0;
        r_rd    <= '0;
        r_alu   <= '0;
        r_sd    <= '0;
        if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        // Writes to r0 are dropped here so forwarding never matches on r0.
        r_valid <= bus.valid_ex;
        r_rw    <= bus.regWrite_ex & bus.valid_ex & (bus.rd_ex != '0);
        r_load  <= bus.load_ex & bus.valid_ex;
        r_store <= bus.store_ex & bus.valid_ex;
        r_rd    <= bus.rd_ex;
        r_alu   <= bus.aluResult_ex;
        r_sd    <= bus.storeData_ex;
      end
    end
  end

  assign bus.valid_mem     = r_valid;
  assign bus.regWrite_mem  = r_rw;
  assign bus.load_mem      = r_load;
  assign bus.store_mem     = r_store;
  assign bus.rd_mem        = r_rd;
  assign bus.aluResult_mem = r_alu;
  assign bus.storeData_mem = r_sd;
  assign bus.loadUse_stall = w_lu_stall;
  assign bus.loadUseCount  = r_cnt;
endmodule

// File: tb/tb_ex_mem_latch.sv
// tb/tb_ex_mem_latch.sv - testbench for ex_mem_latch
// Directed scenarios plus randomized cycles checked against a reference model.
module tb_ex_mem_latch;
  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int W_ALL   = 4 + REG_W + 2 * DATA_W + CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_latch_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();
  ex_mem_latch #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the instruction currently sitting in MEM, plus the bubble count.
  bit                m_valid, m_rw, m_load, m_store;
  int                m_rd;
  logic [DATA_W-1:0] m_alu, m_sd;
  int                m_cnt;

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_load = 0; m_store = 0;
    m_rd = 0; m_alu = '0; m_sd = '0; m_cnt = 0;
  endtask

  function automatic bit model_hit();
    bit reads_rd;
    reads_rd = (bus.usesRs1_ex && int'(bus.rs1_ex) == m_rd) ||
               (bus.usesRs2_ex && int'(bus.rs2_ex) == m_rd);
    return m_valid && m_load && m_rw && bus.valid_ex && reads_rd;
  endfunction

  task automatic tick();
    bit interlock;
    interlock = model_hit() && !bus.flush;
    @(posedge clk);
    if (bus.flush) begin
      m_valid = 0; m_rw = 0; m_load = 0; m_store = 0; m_rd = 0; m_alu = '0; m_sd = '0;
    end else if (!bus.stall) begin
      if (interlock) begin
        m_valid = 0; m_rw = 0; m_load = 0; m_store = 0; m_rd = 0; m_alu = '0; m_sd = '0;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end else begin
        m_valid = bus.valid_ex;
        m_rw    = bus.regWrite_ex && bus.valid_ex && (bus.rd_ex != 0);
        m_load  = bus.load_ex && bus.valid_ex;
        m_store = bus.store_ex && bus.valid_ex;
        m_rd    = int'(bus.rd_ex);
        m_alu   = bus.aluResult_ex;
        m_sd    = bus.storeData_ex;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    bus.stall = 0; bus.flush = 0; bus.valid_ex = 0; bus.rd_ex = '0;
    bus.regWrite_ex = 0; bus.load_ex = 0; bus.store_ex = 0;
    bus.rs1_ex = '0; bus.rs2_ex = '0; bus.usesRs1_ex = 0; bus.usesRs2_ex = 0;
    bus.aluResult_ex = '0; bus.storeData_ex = '0;
  endtask

  task automatic set_load(input int rd);
    set_idle();
    bus.valid_ex = 1; bus.load_ex = 1; bus.regWrite_ex = 1;
    bus.rd_ex = REG_W'(rd); bus.aluResult_ex = $urandom;
  endtask

  task automatic set_use2(input int rs, input bit uses);
    set_idle();
    bus.valid_ex = 1; bus.regWrite_ex = 1; bus.rd_ex = REG_W'(6);
    bus.rs2_ex = REG_W'(rs); bus.usesRs2_ex = uses; bus.aluResult_ex = $urandom;
  endtask

  task automatic test_reset();
    set_idle();
    #12 rst_n = 1;
    model_reset();
    bus.valid_ex = 1; bus.rd_ex = 7; bus.regWrite_ex = 1;
    tick();
    n_vec++; if (bus.valid_mem !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got=%0d exp=1", bus.valid_mem); end
    #2 rst_n = 0;
    #1;
    n_vec++; if ({bus.valid_mem, bus.regWrite_mem, bus.load_mem, bus.store_mem} !== 4'b0) begin n_err++; $display("FAIL rst_ctrl got=%b exp=0000", {bus.valid_mem, bus.regWrite_mem, bus.load_mem, bus.store_mem}); end
    n_vec++; if (bus.rd_mem !== '0) begin n_err++; $display("FAIL rst_rd got=%0d exp=0", bus.rd_mem); end
    n_vec++; if (bus.loadUseCount !== '0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", bus.loadUseCount); end
    model_reset();
    #1 rst_n = 1;
    set_load(5);
    tick();
    set_use2(5, 1);
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b1) begin n_err++; $display("FAIL rst_mid_hit got=%0d exp=1", bus.loadUse_stall); end
    #1 rst_n = 0;
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b0 || bus.loadUseCount !== '0) begin n_err++; $display("FAIL rst_mid_abandon stall=%0d cnt=%0d exp=0,0", bus.loadUse_stall, bus.loadUseCount); end
    model_reset();
    #1 rst_n = 1;
    set_idle();
    tick();
  endtask

  task automatic test_capture();
    set_idle();
    bus.valid_ex = 1; bus.rd_ex = 3; bus.regWrite_ex = 1; bus.aluResult_ex = 32'h0000_1234;
    tick();
    n_vec++; if (bus.rd_mem !== 5'd3) begin n_err++; $display("FAIL cap_rd got=%0d exp=3", bus.rd_mem); end
    n_vec++; if (bus.regWrite_mem !== 1'b1) begin n_err++; $display("FAIL cap_rw got=%0d exp=1", bus.regWrite_mem); end
    n_vec++; if (bus.aluResult_mem !== 32'h1234) begin n_err++; $display("FAIL cap_alu got=%h exp=00001234", bus.aluResult_mem); end
    n_vec++; if (bus.valid_mem !== 1'b1) begin n_err++; $display("FAIL cap_valid got=%0d exp=1", bus.valid_mem); end
    bus.rd_ex = 0;
    tick();
    n_vec++; if (bus.regWrite_mem !== 1'b0 || bus.valid_mem !== 1'b1) begin n_err++; $display("FAIL cap_r0 rw=%0d valid=%0d exp=0,1", bus.regWrite_mem, bus.valid_mem); end
  endtask

  task automatic test_load_use();
    int c0;
    set_load(5);
    tick();
    set_use2(5, 1);
    c0 = m_cnt;
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%0d exp=1", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.valid_mem !== 1'b0 || bus.load_mem !== 1'b0) begin n_err++; $display("FAIL lu_bubble valid=%0d load=%0d exp=0,0", bus.valid_mem, bus.load_mem); end
    n_vec++; if (int'(bus.loadUseCount) !== c0 + 1) begin n_err++; $display("FAIL lu_cnt got=%0d exp=%0d", bus.loadUseCount, c0 + 1); end
    n_vec++; if (bus.loadUse_stall !== 1'b0) begin n_err++; $display("FAIL lu_release got=%0d exp=0", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.valid_mem !== 1'b1 || bus.rd_mem !== 5'd6) begin n_err++; $display("FAIL lu_consumer valid=%0d rd=%0d exp=1,6", bus.valid_mem, bus.rd_mem); end
    set_load(5);
    tick();
    set_use2(5, 0);
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b0) begin n_err++; $display("FAIL lu_nouse got=%0d exp=0", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.valid_mem !== 1'b1 || int'(bus.loadUseCount) !== c0 + 1) begin n_err++; $display("FAIL lu_nouse_pass valid=%0d cnt=%0d exp=1,%0d", bus.valid_mem, bus.loadUseCount, c0 + 1); end
  endtask

  task automatic test_stall_priority();
    int c0;
    set_load(5);
    tick();
    set_use2(5, 1);
    bus.stall = 1;
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (bus.loadUse_stall !== 1'b1) begin n_err++; $display("FAIL st_hold_stall[%0d] got=%0d exp=1", i, bus.loadUse_stall); end
      tick();
      n_vec++; if (bus.rd_mem !== 5'd5 || bus.load_mem !== 1'b1 || int'(bus.loadUseCount) !== c0) begin n_err++; $display("FAIL st_frozen[%0d] rd=%0d load=%0d cnt=%0d exp=5,1,%0d", i, bus.rd_mem, bus.load_mem, bus.loadUseCount, c0); end
    end
    bus.stall = 0;
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b1) begin n_err++; $display("FAIL st_release_stall got=%0d exp=1", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.valid_mem !== 1'b0 || int'(bus.loadUseCount) !== c0 + 1) begin n_err++; $display("FAIL st_one_bubble valid=%0d cnt=%0d exp=0,%0d", bus.valid_mem, bus.loadUseCount, c0 + 1); end
    n_vec++; if (bus.loadUse_stall !== 1'b0) begin n_err++; $display("FAIL st_after got=%0d exp=0", bus.loadUse_stall); end
  endtask

  task automatic test_flush();
    int c0;
    set_load(5);
    tick();
    set_use2(5, 1);
    bus.store_ex = 1; bus.flush = 1;
    c0 = m_cnt;
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b0) begin n_err++; $display("FAIL fl_stall got=%0d exp=0", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.valid_mem !== 1'b0 || bus.store_mem !== 1'b0) begin n_err++; $display("FAIL fl_bubble valid=%0d store=%0d exp=0,0", bus.valid_mem, bus.store_mem); end
    n_vec++; if (int'(bus.loadUseCount) !== c0) begin n_err++; $display("FAIL fl_cnt got=%0d exp=%0d", bus.loadUseCount, c0); end
    set_idle();
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = m_cnt;
    set_load(1);
    tick();
    set_load(2);
    bus.rs1_ex = 1; bus.usesRs1_ex = 1;
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b1) begin n_err++; $display("FAIL b2b_first got=%0d exp=1", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.loadUse_stall !== 1'b0) begin n_err++; $display("FAIL b2b_no_double got=%0d exp=0", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.load_mem !== 1'b1 || bus.rd_mem !== 5'd2) begin n_err++; $display("FAIL b2b_load2 load=%0d rd=%0d exp=1,2", bus.load_mem, bus.rd_mem); end
    set_use2(2, 1);
    #1;
    n_vec++; if (bus.loadUse_stall !== 1'b1) begin n_err++; $display("FAIL b2b_second got=%0d exp=1", bus.loadUse_stall); end
    tick();
    n_vec++; if (bus.loadUse_stall !== 1'b0 || int'(bus.loadUseCount) !== c0 + 2) begin n_err++; $display("FAIL b2b_count stall=%0d cnt=%0d exp=0,%0d", bus.loadUse_stall, bus.loadUseCount, c0 + 2); end
    tick();
  endtask

  task automatic test_random();
    logic [W_ALL-1:0] got, exp;
    bit exp_stall;
    for (int i = 0; i < 600; i++) begin
      bus.valid_ex = ($urandom % 4) != 0;
      bus.rd_ex = REG_W'($urandom % 4);
      bus.rs1_ex = REG_W'($urandom % 4);
      bus.rs2_ex = REG_W'($urandom % 4);
      bus.regWrite_ex = ($urandom % 4) != 0;
      bus.load_ex = ($urandom % 2) != 0;
      bus.store_ex = ($urandom % 3) == 0;
      bus.usesRs1_ex = ($urandom % 2) != 0;
      bus.usesRs2_ex = ($urandom % 2) != 0;
      bus.aluResult_ex = $urandom;
      bus.storeData_ex = $urandom;
      bus.stall = ($urandom % 6) == 0;
      bus.flush = ($urandom % 10) == 0;
      exp_stall = model_hit() && !bus.flush;
      #1;
      n_vec++; if (bus.loadUse_stall !== exp_stall) begin n_err++; $display("FAIL rnd_stall[%0d] got=%0d exp=%0d", i, bus.loadUse_stall, exp_stall); end
      tick();
      got = {bus.valid_mem, bus.regWrite_mem, bus.load_mem, bus.store_mem, bus.rd_mem,
             bus.aluResult_mem, bus.storeData_mem, bus.loadUseCount};
      exp = {m_valid, m_rw, m_load, m_store, REG_W'(m_rd), m_alu, m_sd, CNT_W'(m_cnt)};
      n_vec++; if (got !== exp) begin n_err++; $display("FAIL rnd_mem[%0d] got=%h exp=%h", i, got, exp); end
    end
    set_idle();
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      set_load(5);
      tick();
      set_use2(5, 1);
      tick();
      n_vec++; if (int'(bus.loadUseCount) !== m_cnt) begin n_err++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, bus.loadUseCount, m_cnt); end
    end
    n_vec++; if (int'(bus.loadUseCount) !== CNT_MAX) begin n_err++; $display("FAIL sat_final got=%0d exp=%0d", bus.loadUseCount, CNT_MAX); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_stall_priority();
    test_flush();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
